// File: rtl/space_invaders_pkg.sv
// Shared geometry defaults, hit-detect FSM states and scoring helper for the
// alien grid blocks.
package space_invaders_pkg;

  localparam int DEF_ROWS      = 5;
  localparam int DEF_COLS      = 11;
  localparam int DEF_COL_PITCH = 16;
  localparam int DEF_ROW_PITCH = 16;
  localparam int DEF_ALIEN_W   = 12;
  localparam int DEF_ALIEN_H   = 8;

  typedef enum logic [1:0] {
    S_ACTIVE  = 2'd0,
    S_HOLD    = 2'd1,
    S_CLEARED = 2'd2
  } state_e;

  // Top row is worth the most; rows 1-2 are mid value, everything below is 10.
  function automatic logic [5:0] row_points(input logic [7:0] row);
    if (row == 8'd0)       return 6'd30;
    else if (row <= 8'd2)  return 6'd20;
    else                   return 6'd10;
  endfunction

endpackage

// File: rtl/alien_cell_decode.sv
// Maps a grid-relative bullet offset to a (row, col) cell and flags whether it
// lands inside the hittable sprite area of that cell. Pitches are powers of two.
module alien_cell_decode
  import space_invaders_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int COL_PITCH = DEF_COL_PITCH,
  parameter int ROW_PITCH = DEF_ROW_PITCH,
  parameter int ALIEN_W   = DEF_ALIEN_W,
  parameter int ALIEN_H   = DEF_ALIEN_H,
  parameter int RW        = 3,
  parameter int CW        = 4
) (
  input  logic signed [10:0] dx_i,
  input  logic signed [9:0]  dy_i,
  output logic [RW-1:0]      row_o,
  output logic [CW-1:0]      col_o,
  output logic               in_cell_o
);

  localparam int CSH = $clog2(COL_PITCH);
  localparam int RSH = $clog2(ROW_PITCH);

  logic [10:0] dx_u;
  logic [9:0]  dy_u;
  logic [10:0] col_full;
  logic [9:0]  row_full;
  logic [10:0] x_off;
  logic [9:0]  y_off;

  assign dx_u     = dx_i;
  assign dy_u     = dy_i;
  assign col_full = dx_u >> CSH;
  assign row_full = dy_u >> RSH;
  assign x_off    = dx_u & 11'(COL_PITCH - 1);
  assign y_off    = dy_u & 10'(ROW_PITCH - 1);

  // Sign bits reject bullets left of / above the grid before any wrap can occur.
  assign in_cell_o = !dx_i[10] && !dy_i[9]
                  && (col_full < 11'(COLS)) && (row_full < 10'(ROWS))
                  && (x_off < 11'(ALIEN_W)) && (y_off < 10'(ALIEN_H));

  assign col_o = col_full[CW-1:0];
  assign row_o = row_full[RW-1:0];

endmodule

// File: rtl/alien_hit_detect.sv
// Three-stage bullet-vs-alien-grid hit detector: offset, cell decode, then
// alive-bitmap lookup with a one-kill-per-bullet FSM and wave restore.
module alien_hit_detect
  import space_invaders_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int COL_PITCH = DEF_COL_PITCH,
  parameter int ROW_PITCH = DEF_ROW_PITCH,
  parameter int ALIEN_W   = DEF_ALIEN_W,
  parameter int ALIEN_H   = DEF_ALIEN_H
) (
  input  logic                 clock,
  input  logic                 global_reset_n,
  input  logic [9:0]           alien_group_x,
  input  logic [8:0]           alien_group_y,
  input  logic                 bullet_valid,
  input  logic [9:0]           bullet_x,
  input  logic [8:0]           bullet_y,
  input  logic                 new_wave,
  output logic                 hit,
  output logic [5:0]           score_points,
  output logic [ROWS*COLS-1:0] alive,
  output logic [5:0]           aliens_remaining,
  output logic                 all_dead
);

  localparam int         N  = ROWS * COLS;
  localparam int         IW = (N > 1) ? $clog2(N) : 1;
  localparam int         RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int         CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [5:0] N6 = 6'(N);

  // Pipeline valids (reset) and datapath payload (unreset).
  logic                s1_valid_q, s2_valid_q, s2_cand_q, s3_valid_q, s3_cand_q;
  logic signed [10:0]  dx_q;
  logic signed [9:0]   dy_q;
  logic [RW-1:0]       s2_row_q, row_w;
  logic [CW-1:0]       s2_col_q, col_w;
  logic                in_cell_w;
  logic [IW-1:0]       idx_w, s3_idx_q;
  logic [5:0]          s3_pts_q;

  state_e              state_q, state_d;
  logic [N-1:0]        alive_q, alive_d;
  logic [5:0]          count_q, count_d;
  logic                hit_q, hit_d;
  logic [5:0]          pts_q, pts_d;

  alien_cell_decode #(
    .ROWS(ROWS), .COLS(COLS), .COL_PITCH(COL_PITCH), .ROW_PITCH(ROW_PITCH),
    .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .RW(RW), .CW(CW)
  ) u_decode (
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .row_o     (row_w),
    .col_o     (col_w),
    .in_cell_o (in_cell_w)
  );

  assign idx_w = IW'(s2_row_q) * IW'(COLS) + IW'(s2_col_q);

  // NOTE: only the valid bits need reset; payload flops are qualified by them,
  // so leaving them unreset is safe and keeps the reset tree small.
  always_ff @(posedge clock) begin
    dx_q     <= {1'b0, bullet_x} - {1'b0, alien_group_x};
    dy_q     <= {1'b0, bullet_y} - {1'b0, alien_group_y};
    s2_row_q <= row_w;
    s2_col_q <= col_w;
    s3_idx_q <= s2_cand_q ? idx_w : '0;
    s3_pts_q <= row_points(8'(s2_row_q));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_cand_q  <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_cand_q  <= 1'b0;
      state_q    <= S_ACTIVE;
      alive_q    <= '1;
      count_q    <= N6;
      hit_q      <= 1'b0;
      pts_q      <= '0;
    end else begin
      s1_valid_q <= bullet_valid & ~new_wave;
      s2_valid_q <= s1_valid_q & ~new_wave;
      s2_cand_q  <= s1_valid_q & in_cell_w & ~new_wave;
      s3_valid_q <= s2_valid_q & ~new_wave;
      s3_cand_q  <= s2_cand_q & ~new_wave;
      state_q    <= state_d;
      alive_q    <= alive_d;
      count_q    <= count_d;
      hit_q      <= hit_d;
      pts_q      <= pts_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    count_d = count_q;
    hit_d   = 1'b0;
    pts_d   = '0;
    if (new_wave) begin
      state_d = S_ACTIVE;
      alive_d = '1;
      count_d = N6;
    end else begin
      unique case (state_q)
        S_ACTIVE: begin
          if (s3_cand_q && alive_q[s3_idx_q]) begin
            hit_d             = 1'b1;
            pts_d             = s3_pts_q;
            alive_d[s3_idx_q] = 1'b0;
            count_d           = count_q - 6'd1;
            state_d           = (count_q == 6'd1) ? S_CLEARED : S_HOLD;
          end
        end
        // Release is judged on the valid aligned with this stage, so trailing
        // samples of the same bullet still in the pipe cannot score again.
        S_HOLD: if (!s3_valid_q) state_d = S_ACTIVE;
        S_CLEARED: ;
        default: state_d = S_ACTIVE;
      endcase
    end
  end

  assign hit              = hit_q;
  assign score_points     = pts_q;
  assign alive            = alive_q;
  assign aliens_remaining = count_q;
  assign all_dead         = (count_q == 6'd0);

endmodule

// File: tb/tb_alien_hit_detect.sv
// Directed bench for alien_hit_detect: vector table for geometry and scoring,
// plus sequences for hold, clear-all, new_wave priority and mid-pipeline reset.
module tb_alien_hit_detect;
  import space_invaders_pkg::*;

  localparam int N = 55;

  logic         clock = 1'b0;
  logic         global_reset_n = 1'b0;
  logic [9:0]   alien_group_x = 10'd100;
  logic [8:0]   alien_group_y = 9'd105;
  logic         bullet_valid = 1'b0;
  logic [9:0]   bullet_x = '0;
  logic [8:0]   bullet_y = '0;
  logic         new_wave = 1'b0;
  logic         hit;
  logic [5:0]   score_points;
  logic [N-1:0] alive;
  logic [5:0]   aliens_remaining;
  logic         all_dead;

  alien_hit_detect dut (
    .clock            (clock),
    .global_reset_n   (global_reset_n),
    .alien_group_x    (alien_group_x),
    .alien_group_y    (alien_group_y),
    .bullet_valid     (bullet_valid),
    .bullet_x         (bullet_x),
    .bullet_y         (bullet_y),
    .new_wave         (new_wave),
    .hit              (hit),
    .score_points     (score_points),
    .alive            (alive),
    .aliens_remaining (aliens_remaining),
    .all_dead         (all_dead)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Fires one bullet held for `hold` samples; edge 0 is the sampling edge.
  task automatic shoot(input logic [9:0] x, input logic [8:0] y, input int hold,
                       output int hit_edge, output int n_hits, output logic [5:0] pts,
                       output int idle_score);
    hit_edge = -1; n_hits = 0; pts = '0; idle_score = 0;
    bullet_x = x; bullet_y = y; bullet_valid = 1'b1;
    for (int e = 0; e < hold + 8; e++) begin
      @(posedge clock); #1;
      if (e == hold - 1) bullet_valid = 1'b0;
      if (hit) begin
        n_hits++;
        if (hit_edge < 0) begin hit_edge = e; pts = score_points; end
      end else if (score_points != 6'd0) idle_score++;
    end
  endtask

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    int         hold;
    bit         exp_hit;
    logic [5:0] exp_pts;
    int         kill_idx;
  } vec_t;

  vec_t         vecs [13];
  logic [N-1:0] exp_alive;
  int           exp_rem;
  int           he, nh, idle;
  logic [5:0]   pts;
  int           row, col, saw_hit;
  logic [5:0]   want_pts;

  initial begin
    vecs[0]  = '{10'd100, 9'd105, 1,  1'b1, 6'd30, 0};
    vecs[1]  = '{10'd113, 9'd105, 1,  1'b0, 6'd0,  0};
    vecs[2]  = '{10'd99,  9'd105, 1,  1'b0, 6'd0,  0};
    vecs[3]  = '{10'd100, 9'd170, 10, 1'b1, 6'd10, 44};
    vecs[4]  = '{10'd100, 9'd170, 1,  1'b0, 6'd0,  0};
    vecs[5]  = '{10'd116, 9'd121, 1,  1'b1, 6'd20, 12};
    vecs[6]  = '{10'd143, 9'd137, 1,  1'b1, 6'd20, 24};
    vecs[7]  = '{10'd100, 9'd113, 1,  1'b0, 6'd0,  0};
    vecs[8]  = '{10'd271, 9'd144, 1,  1'b1, 6'd20, 32};
    vecs[9]  = '{10'd276, 9'd105, 1,  1'b0, 6'd0,  0};
    vecs[10] = '{10'd100, 9'd185, 1,  1'b0, 6'd0,  0};
    vecs[11] = '{10'd100, 9'd104, 1,  1'b0, 6'd0,  0};
    vecs[12] = '{10'd100, 9'd153, 1,  1'b1, 6'd10, 33};

    // Reset state
    #12;
    check("rst_alive", alive, {N{1'b1}});
    check("rst_remaining", aliens_remaining, 55);
    check("rst_hit", hit, 0);
    check("rst_score", score_points, 0);
    check("rst_all_dead", all_dead, 0);
    @(negedge clock); global_reset_n = 1'b1;
    @(posedge clock); #1;

    exp_alive = {N{1'b1}};
    exp_rem   = 55;
    for (int i = 0; i < 13; i++) begin
      shoot(vecs[i].x, vecs[i].y, vecs[i].hold, he, nh, pts, idle);
      if (vecs[i].exp_hit) begin
        exp_alive[vecs[i].kill_idx] = 1'b0;
        exp_rem--;
      end
      check($sformatf("v%0d_hits", i), nh, vecs[i].exp_hit ? 1 : 0);
      if (vecs[i].exp_hit) begin
        check($sformatf("v%0d_latency", i), he, 3);
        check($sformatf("v%0d_points", i), pts, vecs[i].exp_pts);
      end
      check($sformatf("v%0d_alive", i), alive, exp_alive);
      check($sformatf("v%0d_remaining", i), aliens_remaining, exp_rem);
      check($sformatf("v%0d_idle_score", i), idle, 0);
    end

    // Clear every surviving alien
    for (int k = 0; k < N; k++) begin
      if (exp_alive[k]) begin
        row = k / 11; col = k % 11;
        want_pts = (row == 0) ? 6'd30 : (row <= 2) ? 6'd20 : 6'd10;
        shoot(10'(100 + 16 * col), 9'(105 + 16 * row), 1, he, nh, pts, idle);
        exp_alive[k] = 1'b0;
        exp_rem--;
        check($sformatf("clr%0d_hits", k), nh, 1);
        check($sformatf("clr%0d_points", k), pts, want_pts);
      end
    end
    check("clr_alive", alive, '0);
    check("clr_remaining", aliens_remaining, 0);
    check("clr_all_dead", all_dead, 1);
    check("clr_state", dut.state_q, S_CLEARED);
    shoot(10'd100, 9'd105, 3, he, nh, pts, idle);
    check("cleared_ignore_hits", nh, 0);
    check("cleared_still", dut.state_q, S_CLEARED);

    new_wave = 1'b1;
    @(posedge clock); #1;
    new_wave = 1'b0;
    check("wave_remaining", aliens_remaining, 55);
    check("wave_alive", alive, {N{1'b1}});
    check("wave_all_dead", all_dead, 0);
    check("wave_state", dut.state_q, S_ACTIVE);

    // new_wave coinciding with the hit decision edge wins
    saw_hit = 0;
    bullet_x = 10'd100; bullet_y = 9'd105; bullet_valid = 1'b1;
    @(posedge clock); #1; bullet_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1; new_wave = 1'b1;
    @(posedge clock); #1; new_wave = 1'b0;
    if (hit) saw_hit++;
    for (int e = 0; e < 5; e++) begin
      @(posedge clock); #1;
      if (hit) saw_hit++;
    end
    check("nw_prio_hits", saw_hit, 0);
    check("nw_prio_remaining", aliens_remaining, 55);

    // Kill one, then reset while a new candidate is mid-pipeline
    shoot(10'd116, 9'd105, 1, he, nh, pts, idle);
    check("pre_rst_hits", nh, 1);
    check("pre_rst_remaining", aliens_remaining, 54);
    saw_hit = 0;
    bullet_x = 10'd100; bullet_y = 9'd105; bullet_valid = 1'b1;
    @(posedge clock); #1; bullet_valid = 1'b0;
    @(posedge clock); #1; global_reset_n = 1'b0;
    #1;
    check("mid_rst_alive", alive, {N{1'b1}});
    @(negedge clock); global_reset_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge clock); #1;
      if (hit) saw_hit++;
    end
    check("post_rst_hits", saw_hit, 0);
    check("post_rst_alive", alive, {N{1'b1}});
    check("post_rst_remaining", aliens_remaining, 55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alien_hit_detect.md
ALIEN_HIT_DETECT -- requirements
Module: alien_hit_detect

Interface
REQ-001 SHALL have parameter ROWS, default 5, meaning alien grid rows.
REQ-002 SHALL have parameter COLS, default 11, meaning alien grid columns.
REQ-003 SHALL have parameter COL_PITCH, default 16, meaning horizontal pixels per cell (power of two).
REQ-004 SHALL have parameter ROW_PITCH, default 16, meaning vertical pixels per cell (power of two).
REQ-005 SHALL have parameter ALIEN_W, default 12, meaning hittable width within a cell, left-aligned.
REQ-006 SHALL have parameter ALIEN_H, default 8, meaning hittable height within a cell, top-aligned.
REQ-007 SHALL have port clock, input, 1, meaning the single system clock.
REQ-008 SHALL have port global_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port alien_group_x, input, 10, meaning grid top-left x from the group-location stage.
REQ-010 SHALL have port alien_group_y, input, 9, meaning grid top-left y.
REQ-011 SHALL have port bullet_valid, input, 1, meaning a player bullet is in flight.
REQ-012 SHALL have port bullet_x, input, 10, meaning bullet pixel x.
REQ-013 SHALL have port bullet_y, input, 9, meaning bullet pixel y.
REQ-014 SHALL have port new_wave, input, 1, meaning a one-cycle pulse that restores all aliens.
REQ-015 SHALL have port hit, output, 1, meaning a one-cycle pulse when an alive alien is struck.
REQ-016 SHALL have port score_points, output, 6, meaning points for the hit (30/20/10), valid only while hit is high, else 0.
REQ-017 SHALL have port alive, output, ROWS*COLS, meaning the alive bitmap, bit index row*COLS+col, row 0 at top.
REQ-018 SHALL have port aliens_remaining, output, 6, meaning the popcount of alive.
REQ-019 SHALL have port all_dead, output, 1, meaning high while aliens_remaining is 0.

Function
REQ-020 SHALL form dx = bullet_x - alien_group_x and dy = bullet_y - alien_group_y as signed 11/10-bit values registered in stage 1 together with bullet_valid.
REQ-021 SHALL, in stage 2, treat the bullet as a candidate only when dx >= 0, dy >= 0, col = dx/COL_PITCH < COLS, row = dy/ROW_PITCH < ROWS, dx mod COL_PITCH < ALIEN_W and dy mod ROW_PITCH < ALIEN_H, using shifts and masks with no dividers.
REQ-022 SHALL, in stage 3, assert hit for exactly one cycle, clear alive[row*COLS+col] and decrement aliens_remaining when the candidate bit is 1; a candidate on a dead bit is a miss.
REQ-023 SHALL give hit latency of 3 clock edges from the edge sampling bullet_valid/coords to the edge at which hit rises.
REQ-024 SHALL provide score_points = 30 for row 0, 20 for rows 1-2 and 10 for rows 3 and above.
REQ-025 SHALL implement FSM states S_ACTIVE, S_HOLD and S_CLEARED.
REQ-026 SHALL transition S_ACTIVE->S_HOLD on hit, and S_HOLD->S_ACTIVE on the first cycle bullet_valid is sampled low; in S_HOLD, candidates are discarded so one bullet kills at most one alien.
REQ-027 SHALL enter S_CLEARED when the last alien is cleared and remain there, ignoring bullets, until new_wave.
REQ-028 SHALL, on new_wave in any state, set alive to all ones, set aliens_remaining to ROWS*COLS, flush pipeline valids, and go to S_ACTIVE next cycle; new_wave wins over a same-cycle hit.
REQ-029 SHALL leave alive unchanged when bullet_valid is low.

Reset
REQ-030 SHALL, while global_reset_n is low, asynchronously force alive to all ones, aliens_remaining to ROWS*COLS, hit to 0, score_points to 0, all_dead to 0, the pipeline valids to 0 and the state to S_ACTIVE.
REQ-031 SHALL discard any in-flight candidate when reset is asserted mid-pipeline, producing no hit after release.

Structure
REQ-032 SHALL take grid geometry defaults and the state enum from the shared package space_invaders_pkg.
REQ-033 SHALL place the stage-2 cell decode (dx/dy to row, col, in_cell) in sub-module alien_cell_decode.

Verification
REQ-034 Bench SHALL cover: group (100,105), bullet (100,105) valid -> hit 3 edges later, score 30, alive[0] clears, remaining 54.
REQ-035 Bench SHALL cover: bullet (113,105) (dx mod 16 = 13) -> no hit, bitmap unchanged.
REQ-036 Bench SHALL cover: bullet held at (100,170) for 10 cycles -> exactly one hit at row 4 col 0, score 10; then a second bullet at the same spot -> miss.
REQ-037 Bench SHALL cover: bullet at x 99, left of the group -> no hit, with no wraparound hit on col 10.
REQ-038 Bench SHALL cover: clear all 55 aliens -> all_dead high, S_CLEARED, further bullets ignored; new_wave -> 55 remaining next cycle.
REQ-039 Bench SHALL cover: global_reset_n pulled low one cycle after a valid hit candidate -> no hit pulse, bitmap all ones.
